// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, optional parity, 1 or 2 stops.
// Integer baud divider, valid/ready byte input, registered glitch-free tx.
module uart_tx #(
   parameter int clock_frequency = 12000000,
   parameter int baud_rate       = 9600,
   parameter int parity          = 0,
   parameter int stop_bits       = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CLKS_PER_BIT = clock_frequency / baud_rate;
   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] STOP_LAST = 3'(stop_bits - 1);

   if (parity < 0 || parity > 2) begin : g_bad_parity
      $error("uart_tx: parity must be 0, 1 or 2");
   end
   if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
      $error("uart_tx: stop_bits must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_div
      $error("uart_tx: clock_frequency / baud_rate must be >= 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state, state_n;
   logic [DIV_W-1:0] div, div_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shift, shift_n;
   logic             par, par_n;
   logic             tx_n;
   logic             bit_end;

   // Next-state, divider, shifter and next line level.
   always_comb begin
      state_n   = state;
      div_n     = div;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      par_n     = par;
      tx_n      = 1'b1;
      bit_end   = (div == DIV_MAX);

      unique case (state)
         IDLE: begin
            div_n     = '0;
            bit_cnt_n = '0;
            if (tx_valid && tx_ready) begin
               state_n = START;
               shift_n = tx_data;
               if (parity == 1) begin
                  par_n = ~^tx_data;
               end else if (parity == 2) begin
                  par_n = ^tx_data;
               end else begin
                  par_n = 1'b0;
               end
            end
         end
         START: begin
            if (bit_end) begin
               div_n   = '0;
               state_n = DATA;
            end else begin
               div_n = div + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               div_n   = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  bit_cnt_n = '0;
                  state_n   = (parity != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end else begin
               div_n = div + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               div_n   = '0;
               state_n = STOP;
            end else begin
               div_n = div + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               div_n = '0;
               if (bit_cnt == STOP_LAST) begin
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end else begin
               div_n = div + 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            div_n     = '0;
            bit_cnt_n = '0;
         end
      endcase

      // The pin level is decided from the state being entered so the
      // flop below presents it in the same cycle the state changes.
      unique case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
   end

   // State, datapath and registered outputs; reset forces the line idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         div      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par      <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         div      <= div_n;
         bit_cnt  <= bit_cnt_n;
         shift    <= shift_n;
         par      <= par_n;
         tx       <= tx_n;
         tx_ready <= (state_n == IDLE);
         busy     <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx across parity/stop variants.
// Instances: 0 none/1, 1 even/1, 2 odd/1, 3 even/2 (10 clk/bit), 4 defaults.
module tb_uart_tx;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data  = 8'h00;
   logic [4:0] valid = '0;
   wire  [4:0] txw;
   wire  [4:0] rdy;
   wire  [4:0] bsy;

   int checks = 0;
   int errors = 0;

   logic rec_tx  [0:12699];
   logic rec_rdy [0:12699];
   logic rec_bsy [0:12699];

   always #5 clk = ~clk;

   uart_tx #(.clock_frequency(1000000), .baud_rate(100000),
             .parity(0), .stop_bits(1)) u_p0 (
      .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid[0]),
      .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]));

   uart_tx #(.clock_frequency(1000000), .baud_rate(100000),
             .parity(2), .stop_bits(1)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid[1]),
      .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]));

   uart_tx #(.clock_frequency(1000000), .baud_rate(100000),
             .parity(1), .stop_bits(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid[2]),
      .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]));

   uart_tx #(.clock_frequency(1000000), .baud_rate(100000),
             .parity(2), .stop_bits(2)) u_even2 (
      .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid[3]),
      .tx_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]));

   uart_tx u_def (
      .clk(clk), .rst_n(rst_n), .tx_data(data), .tx_valid(valid[4]),
      .tx_ready(rdy[4]), .tx(txw[4]), .busy(bsy[4]));

   function automatic logic exp_bit(input logic [7:0] d, input int pm,
                                    input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (pm != 0 && b == 9) return (pm == 1) ? ~^d : ^d;
      return 1'b1;
   endfunction

   task automatic send(input int idx, input logic [7:0] d, input bit keep);
      bit ok;
      ok = 1'b0;
      data = d;
      valid[idx] = 1'b1;
      for (int n = 0; n < 20000 && !ok; n++) begin
         @(negedge clk);
         if (rdy[idx] === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout idx=%0d ready=%b expected 1",
                  idx, rdy[idx]);
      end
      @(posedge clk);
      #1;
      if (!keep) valid[idx] = 1'b0;
   endtask

   task automatic record(input int idx, input int n, input int drop);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rec_tx[i]  = txw[idx];
         rec_rdy[i] = rdy[idx];
         rec_bsy[i] = bsy[idx];
         if (i == drop) valid[idx] = 1'b0;
      end
   endtask

   task automatic test_reset;
      int bad_tx, bad_rdy, bad_bsy;
      bad_tx = 0; bad_rdy = 0; bad_bsy = 0;
      rst_n = 1'b0;
      valid = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (txw !== 5'h1f) begin
         errors++;
         $display("FAIL reset_tx got=%b expected=11111", txw);
      end
      checks++;
      if (rdy !== 5'h1f) begin
         errors++;
         $display("FAIL reset_ready got=%b expected=11111", rdy);
      end
      checks++;
      if (bsy !== 5'h00) begin
         errors++;
         $display("FAIL reset_busy got=%b expected=00000", bsy);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (txw !== 5'h1f) bad_tx++;
         if (rdy !== 5'h1f) bad_rdy++;
         if (bsy !== 5'h00) bad_bsy++;
      end
      checks++;
      if (bad_tx !== 0) begin
         errors++;
         $display("FAIL idle_tx bad_cycles=%0d expected 0", bad_tx);
      end
      checks++;
      if (bad_rdy !== 0) begin
         errors++;
         $display("FAIL idle_ready bad_cycles=%0d expected 0", bad_rdy);
      end
      checks++;
      if (bad_bsy !== 0) begin
         errors++;
         $display("FAIL idle_busy bad_cycles=%0d expected 0", bad_bsy);
      end
   endtask

   task automatic test_single;
      logic [9:0] exp55;
      int mism, bcnt, first_rdy;
      exp55 = 10'b1_0101_0101_0;
      send(0, 8'h55, 1'b0);
      record(0, 120, -1);
      for (int b = 0; b < 10; b++) begin
         mism = 0;
         for (int c = 0; c < 10; c++)
            if (rec_tx[b*10+c] !== exp55[b]) mism++;
         checks++;
         if (mism !== 0) begin
            errors++;
            $display("FAIL frame55 bit%0d tx=%b expected=%b", b,
                     rec_tx[b*10+5], exp55[b]);
         end
      end
      bcnt = 0;
      first_rdy = -1;
      for (int i = 0; i < 120; i++) begin
         if (rec_bsy[i] === 1'b1) bcnt++;
         if (first_rdy < 0 && rec_rdy[i] === 1'b1) first_rdy = i;
      end
      checks++;
      if (bcnt !== 100) begin
         errors++;
         $display("FAIL busy55 cycles=%0d expected=100", bcnt);
      end
      checks++;
      if (first_rdy + 1 !== 101) begin
         errors++;
         $display("FAIL ready55 low_span=%0d expected=101", first_rdy + 1);
      end
      checks++;
      if (rec_tx[100] !== 1'b1 || rec_bsy[99] !== 1'b1) begin
         errors++;
         $display("FAIL end55 tx=%b busy_last=%b expected tx=1 busy_last=1",
                  rec_tx[100], rec_bsy[99]);
      end
   endtask

   task automatic test_parity;
      int mism, bcnt, hi;
      for (int k = 1; k <= 2; k++) begin
         send(k, 8'hA3, 1'b0);
         record(k, 130, -1);
         for (int b = 0; b < 11; b++) begin
            mism = 0;
            for (int c = 0; c < 10; c++)
               if (rec_tx[b*10+c] !== exp_bit(8'hA3, (k == 1) ? 2 : 1, b))
                  mism++;
            checks++;
            if (mism !== 0) begin
               errors++;
               $display("FAIL parA3 inst%0d bit%0d tx=%b", k, b,
                        rec_tx[b*10+5]);
            end
         end
         checks++;
         if (rec_tx[95] !== ((k == 1) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL parbit inst%0d got=%b expected=%b", k,
                     rec_tx[95], (k == 1) ? 1'b0 : 1'b1);
         end
         bcnt = 0;
         for (int i = 0; i < 130; i++) if (rec_bsy[i] === 1'b1) bcnt++;
         checks++;
         if (bcnt !== 110) begin
            errors++;
            $display("FAIL parlen inst%0d cycles=%0d expected=110", k, bcnt);
         end
      end
      send(3, 8'hA3, 1'b0);
      record(3, 130, -1);
      checks++;
      if (rec_tx[95] !== 1'b0) begin
         errors++;
         $display("FAIL par2stop_bit got=%b expected=0", rec_tx[95]);
      end
      hi = 0;
      bcnt = 0;
      for (int i = 100; i < 120; i++) if (rec_tx[i] === 1'b1) hi++;
      for (int i = 0; i < 130; i++) if (rec_bsy[i] === 1'b1) bcnt++;
      checks++;
      if (hi !== 20) begin
         errors++;
         $display("FAIL stop2_high cycles=%0d expected=20", hi);
      end
      checks++;
      if (bcnt !== 120 || rec_rdy[120] !== 1'b1) begin
         errors++;
         $display("FAIL stop2_len busy=%0d ready120=%b expected 120 and 1",
                  bcnt, rec_rdy[120]);
      end
   endtask

   task automatic test_back_to_back;
      int mism;
      send(0, 8'h00, 1'b1);
      data = 8'hFF;
      record(0, 220, 101);
      for (int b = 0; b < 10; b++) begin
         mism = 0;
         for (int c = 0; c < 10; c++)
            if (rec_tx[b*10+c] !== exp_bit(8'h00, 0, b)) mism++;
         checks++;
         if (mism !== 0) begin
            errors++;
            $display("FAIL b2b_first bit%0d tx=%b", b, rec_tx[b*10+5]);
         end
      end
      checks++;
      if (rec_tx[100] !== 1'b1 || rec_rdy[100] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap tx=%b ready=%b expected 1 1",
                  rec_tx[100], rec_rdy[100]);
      end
      checks++;
      if (rec_tx[101] !== 1'b0 || rec_rdy[101] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start tx=%b ready=%b expected 0 0",
                  rec_tx[101], rec_rdy[101]);
      end
      for (int b = 0; b < 10; b++) begin
         mism = 0;
         for (int c = 0; c < 10; c++)
            if (rec_tx[101+b*10+c] !== exp_bit(8'hFF, 0, b)) mism++;
         checks++;
         if (mism !== 0) begin
            errors++;
            $display("FAIL b2b_second bit%0d tx=%b", b, rec_tx[106+b*10]);
         end
      end
      checks++;
      if (rec_rdy[201] !== 1'b1 || rec_tx[201] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end ready=%b tx=%b expected 1 1",
                  rec_rdy[201], rec_tx[201]);
      end
   endtask

   task automatic test_reset_mid_frame;
      int mism, bad;
      send(0, 8'h0F, 1'b0);
      repeat (46) @(negedge clk);
      checks++;
      if (bsy[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got=%b expected=1", bsy[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (txw[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset tx=%b busy=%b ready=%b expected 1 0 1",
                  txw[0], bsy[0], rdy[0]);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      record(0, 20, -1);
      bad = 0;
      for (int i = 0; i < 20; i++)
         if (rec_tx[i] !== 1'b1 || rec_bsy[i] !== 1'b0 || rec_rdy[i] !== 1'b1)
            bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL post_reset_idle bad_cycles=%0d expected 0", bad);
      end
      send(0, 8'h81, 1'b0);
      record(0, 110, -1);
      for (int b = 0; b < 10; b++) begin
         mism = 0;
         for (int c = 0; c < 10; c++)
            if (rec_tx[b*10+c] !== exp_bit(8'h81, 0, b)) mism++;
         checks++;
         if (mism !== 0) begin
            errors++;
            $display("FAIL frame81 bit%0d tx=%b", b, rec_tx[b*10+5]);
         end
      end
   endtask

   task automatic test_default;
      logic [7:0] got;
      logic [9:0] exp41;
      int bcnt;
      exp41 = 10'b1_0100_0001_0;
      send(4, 8'h41, 1'b0);
      record(4, 12600, -1);
      for (int b = 1; b <= 8; b++) got[b-1] = rec_tx[b*1250+625];
      checks++;
      if (rec_tx[625] !== 1'b0 || rec_tx[9*1250+625] !== 1'b1) begin
         errors++;
         $display("FAIL def_framing start=%b stop=%b expected 0 1",
                  rec_tx[625], rec_tx[9*1250+625]);
      end
      checks++;
      if (got !== 8'h41) begin
         errors++;
         $display("FAIL def_decode got=%h expected=41", got);
      end
      for (int b = 0; b < 10; b++) begin
         checks++;
         if (rec_tx[b*1250] !== exp41[b] ||
             rec_tx[b*1250+1249] !== exp41[b]) begin
            errors++;
            $display("FAIL def_edges bit%0d first=%b last=%b expected=%b",
                     b, rec_tx[b*1250], rec_tx[b*1250+1249], exp41[b]);
         end
      end
      bcnt = 0;
      for (int i = 0; i < 12600; i++) if (rec_bsy[i] === 1'b1) bcnt++;
      checks++;
      if (bcnt !== 12500 || rec_rdy[12500] !== 1'b1) begin
         errors++;
         $display("FAIL def_len busy=%0d ready=%b expected 12500 1",
                  bcnt, rec_rdy[12500]);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_parity;
      test_back_to_back;
      test_reset_mid_frame;
      test_default;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
